swd_frame_sequencer: RTL and testbench

- Host-side engine directly upstream of swd_frontend_top.
- Accepts one SWD transaction per command: request byte, R/W, write data. It generates the SPI-style stream the frontend consumes (sck, mosi, frontend reset/arm, rnw) and collects ACK, read data and parity from miso.
- Returns one response per command. Runs from a single system clock and derives sck internally.

---
 rtl/swd_seq_pkg.sv | 50 +++++
 rtl/swd_frame_sequencer_if.sv | 26 ++
 rtl/swd_sck_gen.sv | 41 ++++
 rtl/swd_frame_sequencer.sv | 174 +++++++++++++++++
 tb/tb_swd_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/swd_seq_pkg.sv
// Shared definitions for the SWD frame sequencer.
// Contents: FSM state enum, frame bit-index constants, ACK codes, and the
// helper that selects the host-driven mosi level for a given frame bit.
package swd_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StHdr,
    StAck,
    StRdata,
    StWturn,
    StWdata,
    StAbort,
    StResp
  } state_t;

  typedef logic [5:0] bit_idx_t;

  localparam bit_idx_t PAD_END     = 6'd1;
  localparam bit_idx_t REQ_FIRST   = 6'd2;
  localparam bit_idx_t REQ_LAST    = 6'd9;
  localparam bit_idx_t TURN1       = 6'd10;
  localparam bit_idx_t ACK_FIRST   = 6'd11;
  localparam bit_idx_t ACK_LAST    = 6'd13;
  localparam bit_idx_t RDATA_FIRST = 6'd14;
  localparam bit_idx_t WDATA_FIRST = 6'd15;
  localparam bit_idx_t PARITY_R    = 6'd46;
  localparam bit_idx_t LAST_BIT    = 6'd47;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  // Host-driven level for frame bit b; every bit not listed is a 0.
  function automatic logic mosi_bit(input bit_idx_t b, input logic [7:0] req, input logic rnw,
                                    input logic [31:0] wdata);
    logic v;
    v = 1'b0;
    if (b > PAD_END && b <= REQ_LAST) begin
      v = req[3'(b - REQ_FIRST)];
    end else if (!rnw && b >= WDATA_FIRST && b < LAST_BIT) begin
      v = wdata[5'(b - WDATA_FIRST)];
    end else if (!rnw && b == LAST_BIT) begin
      v = ^wdata;
    end
    return v;
  endfunction

endpackage

// File: rtl/swd_frame_sequencer_if.sv
// Command/response handshake bundle of the SWD frame sequencer.
// master: the host issuing commands; slave: the sequencer.
//   cmd_*: valid/ready command with request byte, direction and write data.
//   rsp_*: valid/ready response with ACK, read data and parity error flag.
interface swd_frame_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_req;
  logic        cmd_rnw;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_parity_err;

  modport master (
    output cmd_valid, cmd_req, cmd_rnw, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
  );

  modport slave (
    input  cmd_valid, cmd_req, cmd_rnw, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
  );
endinterface

// File: rtl/swd_sck_gen.sv
// Serial clock divider. While en is high, sck toggles every CLK_DIV clk with the
// low half first; while en is low, sck and the counter are held at 0.
// Ports: clk, rst_n (async active-low), en, sck, rise/fall (one-clk strobes that
// are high on the clk whose edge drives sck high/low).
module swd_sck_gen #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [CNT_W-1:0] cnt_q;
  logic             sck_q;
  logic             half_end;

  assign half_end = en && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise     = half_end && !sck_q;
  assign fall     = half_end && sck_q;
  assign sck      = sck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (half_end) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/swd_frame_sequencer.sv
// SWD frame sequencer: turns one command (request byte, R/W, write data) into
// an ARM period plus a 48-bit SWD frame toward swd_frontend_top, and returns
// ACK, read data and parity status as one response.
// Ports: clk, rst_n (async active-low); bus (slave side of the cmd/rsp
// interface); sck/mosi/miso, fe_rst_n, fe_rnw, fe_oe_n toward the frontend.
// Build option: define SWD_SEQ_PARITY_CHECK_EN to report read-parity
// mismatches on rsp_parity_err; otherwise that output is tied 0.
module swd_frame_sequencer #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  swd_frame_sequencer_if.slave  bus,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  fe_rst_n,
  output logic                  fe_rnw,
  output logic                  fe_oe_n
);
  import swd_seq_pkg::*;

  state_t      state_q;
  bit_idx_t    bit_q;
  logic [7:0]  req_q;
  logic        rnw_q;
  logic [31:0] wdata_q;
  logic [2:0]  ack_q;
  logic [31:0] rdata_q;
  logic        par_q;
  logic        mosi_q;
  logic        fe_rst_n_q;
  logic        fe_rnw_q;
  logic        fe_oe_n_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [2:0]  rsp_ack_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_perr_q;

  logic sck_en;
  logic sck_fall;
  logic unused_sck_rise;
  logic frame_done;
  logic perr_calc;

  assign sck_en = (state_q != StIdle) && (state_q != StResp);

  swd_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_sck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sck_en),
    .sck   (sck),
    .rise  (unused_sck_rise),
    .fall  (sck_fall)
  );

  // The last bit of a frame ends on this falling sck edge.
  assign frame_done = sck_fall &&
      ((state_q == StAbort) ||
       (((state_q == StRdata) || (state_q == StWdata)) && (bit_q == LAST_BIT)));

`ifdef SWD_SEQ_PARITY_CHECK_EN
  assign perr_calc = (^rdata_q) != par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
  assign perr_calc  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_q       <= '0;
      req_q       <= '0;
      rnw_q       <= 1'b1;
      wdata_q     <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      par_q       <= 1'b0;
      mosi_q      <= 1'b0;
      fe_rst_n_q  <= 1'b0;
      fe_rnw_q    <= 1'b1;
      fe_oe_n_q   <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
    end else begin
      fe_oe_n_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            req_q       <= bus.cmd_req;
            rnw_q       <= bus.cmd_rnw;
            wdata_q     <= bus.cmd_wdata;
            fe_rnw_q    <= bus.cmd_rnw;
            ack_q       <= '0;
            rdata_q     <= '0;
            par_q       <= 1'b0;
            bit_q       <= '0;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            state_q     <= StArm;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          if (frame_done) begin
            state_q     <= StResp;
            fe_rst_n_q  <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_ack_q   <= ack_q;
            rsp_rdata_q <= (state_q == StRdata) ? rdata_q : 32'h0;
            rsp_perr_q  <= (state_q == StRdata) && perr_calc;
          end else if (sck_fall) begin
            // mosi for the next bit is launched on the edge that ends this one.
            bit_q  <= bit_q + 6'd1;
            mosi_q <= mosi_bit(bit_q + 6'd1, req_q, rnw_q, wdata_q);
            case (state_q)
              StArm: begin
                fe_rst_n_q <= 1'b1;
                bit_q      <= '0;
                mosi_q     <= 1'b0;
                state_q    <= StHdr;
              end
              StHdr: begin
                if (bit_q == TURN1) state_q <= StAck;
              end
              StAck: begin
                ack_q[2'(bit_q - ACK_FIRST)] <= miso;
                if (bit_q == ACK_LAST) begin
                  if ({miso, ack_q[1:0]} != ACK_OK) state_q <= StAbort;
                  else if (rnw_q)                   state_q <= StRdata;
                  else                              state_q <= StWturn;
                end
              end
              StRdata: begin
                if (bit_q < PARITY_R)       rdata_q[5'(bit_q - RDATA_FIRST)] <= miso;
                else if (bit_q == PARITY_R) par_q <= miso;
              end
              StWturn: state_q <= StWdata;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign mosi               = mosi_q;
  assign fe_rst_n           = fe_rst_n_q;
  assign fe_rnw             = fe_rnw_q;
  assign fe_oe_n            = fe_oe_n_q;
  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_ack        = rsp_ack_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_parity_err = rsp_perr_q;

endmodule

// File: tb/tb_swd_frame_sequencer.sv
// Directed bench for swd_frame_sequencer with a small SWD target model on miso.
module tb_swd_frame_sequencer;

`ifdef SWD_SEQ_PARITY_CHECK_EN
  localparam logic EXP_PE = 1'b1;
`else
  localparam logic EXP_PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sck, mosi, miso, fe_rst_n, fe_rnw, fe_oe_n;

  swd_frame_sequencer_if bus ();

  swd_frame_sequencer #(
    .CLK_DIV (2),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .fe_rst_n (fe_rst_n),
    .fe_rnw   (fe_rnw),
    .fe_oe_n  (fe_oe_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          rise_cnt = 0;
  logic [47:0] mosi_cap, rst_cap;
  logic        rnw_or, rnw_and;
  logic [2:0]  tgt_ack;
  logic [31:0] tgt_data;
  logic        tgt_par;
  logic        overlap_seen = 1'b0;
  logic        stall_ok;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tgt_bit(input int b);
    if (b >= 11 && b <= 13) return tgt_ack[b-11];
    if (b >= 14 && b <= 45) return tgt_data[b-14];
    if (b == 46) return tgt_par;
    return 1'b0;
  endfunction

  // Target model: on each rising sck, record the host bit and present the
  // target bit for that position; the first rise of a frame is the ARM period.
  initial begin
    int b;
    miso = 1'b0;
    forever begin
      @(posedge sck);
      b = rise_cnt - 1;
      if (b >= 0 && b < 48) begin
        mosi_cap[b] = mosi;
        rst_cap[b]  = fe_rst_n;
        rnw_or      = rnw_or | fe_rnw;
        rnw_and     = rnw_and & fe_rnw;
      end
      miso = tgt_bit(b);
      rise_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.cmd_ready === 1'b1 && bus.rsp_valid === 1'b1) overlap_seen = 1'b1;
  end

  task automatic start_frame();
    rise_cnt = 0;
    mosi_cap = '0;
    rst_cap  = '0;
    rnw_or   = 1'b0;
    rnw_and  = 1'b1;
  endtask

  task automatic run_cmd(input logic [7:0] req, input logic rnw, input logic [31:0] wdata,
                         input int stall, output logic [2:0] ack, output logic [31:0] rdata,
                         output logic perr, output int lat);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait", n < 100, 1);
    start_frame();
    bus.cmd_valid = 1'b1;
    bus.cmd_req   = req;
    bus.cmd_rnw   = rnw;
    bus.cmd_wdata = wdata;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check_eq("rsp_wait", n < 3000, 1);
    ack      = bus.rsp_ack;
    rdata    = bus.rsp_rdata;
    perr     = bus.rsp_parity_err;
    stall_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rsp_ack !== ack ||
          bus.rsp_rdata !== rdata || bus.rsp_parity_err !== perr) stall_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("rsp_valid_clear", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ack;
    logic [31:0] rd;
    logic        pe;
    int          lat;
    int          n;
    logic        seen;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_req   = '0;
    bus.cmd_rnw   = 1'b0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    tgt_ack       = 3'b001;
    tgt_data      = '0;
    tgt_par       = 1'b0;
    #12;
    check_eq("reset_outs", {sck, mosi, fe_rst_n, fe_rnw, fe_oe_n, bus.cmd_ready, bus.rsp_valid,
                            bus.rsp_ack, bus.rsp_parity_err}, {5'b00011, 2'b00, 3'b000, 1'b0});
    check_eq("reset_rdata", bus.rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_oe_ready", {fe_oe_n, bus.cmd_ready}, 2'b01);

    // Read OK: 0x12345678 has 13 ones, so parity is 1.
    tgt_ack = 3'b001; tgt_data = 32'h12345678; tgt_par = 1'b1;
    run_cmd(8'hA5, 1'b1, 32'h0, 0, ack, rd, pe, lat);
    check_eq("rd_ack", ack, 3'b001);
    check_eq("rd_data", rd, 32'h12345678);
    check_eq("rd_perr", pe, 0);
    check_eq("rd_rises", rise_cnt, 49);
    check_eq("rd_latency", lat, 196);
    check_eq("rd_req_bits", mosi_cap[9:2], 8'hA5);
    check_eq("rd_pad_turn", {mosi_cap[1:0], mosi_cap[10]}, 3'b000);
    check_eq("rd_fe_rnw", rnw_and, 1);

    // Write OK: 0xDEADBEEF has 24 ones, so parity is 0.
    tgt_ack = 3'b001; tgt_data = 32'h0; tgt_par = 1'b0;
    run_cmd(8'h81, 1'b0, 32'hDEADBEEF, 0, ack, rd, pe, lat);
    check_eq("wr_ack", ack, 3'b001);
    check_eq("wr_rdata", rd, 0);
    check_eq("wr_perr", pe, 0);
    check_eq("wr_data_bits", mosi_cap[46:15], 32'hDEADBEEF);
    check_eq("wr_parity_bit", mosi_cap[47], 0);
    check_eq("wr_turn_bit", mosi_cap[14], 0);
    check_eq("wr_req_bits", mosi_cap[9:2], 8'h81);
    check_eq("wr_fe_rnw", rnw_or, 0);
    check_eq("wr_rises", rise_cnt, 49);
    check_eq("wr_latency", lat, 196);

    // WAIT abort: ARM + bits 0..14 = 16 sck periods.
    tgt_ack = 3'b010; tgt_data = 32'hFFFFFFFF; tgt_par = 1'b0;
    run_cmd(8'h8D, 1'b1, 32'h0, 0, ack, rd, pe, lat);
    check_eq("wait_ack", ack, 3'b010);
    check_eq("wait_rdata", rd, 0);
    check_eq("wait_perr", pe, 0);
    check_eq("wait_rises", rise_cnt, 16);
    check_eq("wait_latency", lat, 64);
    check_eq("wait_armed_bits", {rst_cap[0], rst_cap[14]}, 2'b11);
    check_eq("wait_fe_rst_low", fe_rst_n, 0);

    // Parity error: data 1 has odd parity, target sends 0.
    tgt_ack = 3'b001; tgt_data = 32'h00000001; tgt_par = 1'b0;
    run_cmd(8'hA5, 1'b1, 32'h0, 0, ack, rd, pe, lat);
    check_eq("perr_ack", ack, 3'b001);
    check_eq("perr_data", rd, 32'h1);
    check_eq("perr_flag", pe, EXP_PE);

    // Reset during bit 20 of a read (bit b's rise leaves rise_cnt = b + 2).
    tgt_ack = 3'b001; tgt_data = 32'hCAFEF00D; tgt_par = 1'b0;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    start_frame();
    bus.cmd_valid = 1'b1; bus.cmd_req = 8'hA5; bus.cmd_rnw = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (rise_cnt < 22 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("midframe_reached", rise_cnt, 22);
    rst_n = 1'b0;
    #1;
    check_eq("midframe_reset_outs", {sck, mosi, fe_rst_n, fe_rnw, fe_oe_n, bus.cmd_ready,
                                     bus.rsp_valid, bus.rsp_ack, bus.rsp_parity_err},
             {5'b00011, 2'b00, 3'b000, 1'b0});
    check_eq("midframe_reset_rdata", bus.rsp_rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("no_rsp_after_reset", seen, 0);
    // 0x0F0F0F0F has 16 ones, parity 0.
    tgt_data = 32'h0F0F0F0F; tgt_par = 1'b0;
    run_cmd(8'hA5, 1'b1, 32'h0, 0, ack, rd, pe, lat);
    check_eq("after_reset_ack", ack, 3'b001);
    check_eq("after_reset_data", rd, 32'h0F0F0F0F);

    // Backpressure: 10-clk stall on the first response, second read follows at once.
    tgt_data = 32'h11112222; tgt_par = 1'b0;
    run_cmd(8'hB1, 1'b1, 32'h0, 10, ack, rd, pe, lat);
    check_eq("bp_stall_stable", stall_ok, 1);
    check_eq("bp_first_ack", ack, 3'b001);
    check_eq("bp_first_data", rd, 32'h11112222);
    tgt_data = 32'h80000000; tgt_par = 1'b1;
    run_cmd(8'hB1, 1'b1, 32'h0, 0, ack, rd, pe, lat);
    check_eq("bp_second_data", rd, 32'h80000000);
    check_eq("bp_second_perr", pe, 0);

    check_eq("ready_valid_overlap", overlap_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
